seq_mult: RTL

Parametrised sequential shift-add multiplier. Next generation of the team's 4-bit combinational array multiplier. Trades area for latency: one WIDTH-bit adder is reused across WIDTH cycles, controlled by a start/busy/done handshake. Sits beside the passenger/crew adder datapath and multiplies wider operands (e.g. headcount × fare) without growing an O(WIDTH²) adder array.

---
 rtl/seq_mult_pkg.sv | 17 +
 rtl/seq_mult_if.sv | 30 +++
 rtl/adder_wbit.sv | 21 ++
 rtl/seq_mult.sv | 100 ++++++++++
 4 files changed

// File: rtl/seq_mult_pkg.sv
// Shared types and helpers for the seq_mult shift-add multiplier.
package seq_mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIN  = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 4;

    // Iteration counter must reach WIDTH without wrapping.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/seq_mult_if.sv
// Request/response bundle for seq_mult; sgn exists only when SEQ_MULT_SIGNED_EN is defined.
// Handshake: start is a request sampled only while busy=0 (IDLE or FIN); a, b (and sgn) are captured
// on that edge, busy stays high during the WIDTH iterations, done pulses for one cycle with p valid.
interface seq_mult_if #(parameter int WIDTH = 4);
    logic                 start;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
`ifdef SEQ_MULT_SIGNED_EN
    logic                 sgn;
`endif
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   p;

    modport master (
`ifdef SEQ_MULT_SIGNED_EN
        output sgn,
`endif
        output start, a, b,
        input  busy, done, p
    );

    modport slave (
`ifdef SEQ_MULT_SIGNED_EN
        input  sgn,
`endif
        input  start, a, b,
        output busy, done, p
    );
endinterface

// File: rtl/adder_wbit.sv
// WIDTH-bit ripple-carry adder made of chained full-adder cells.
module adder_wbit #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic [WIDTH-1:0] s,
    output logic             c_out
);
    logic [WIDTH:0] c;

    assign c[0] = c_in;

    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign c_out = c[WIDTH];
endmodule

// File: rtl/seq_mult.sv
// Sequential shift-add multiplier reusing one WIDTH-bit adder over WIDTH cycles.
// Optional two's-complement mode is enabled with the macro SEQ_MULT_SIGNED_EN.
module seq_mult
    import seq_mult_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic          clk,
    input  logic          rst,
    seq_mult_if.slave     bus,
    output state_t        state
);
    localparam int CW = cnt_width(WIDTH);

    state_t                state_q, state_d;
    logic [WIDTH-1:0]      mcand_q;
    logic [2*WIDTH-1:0]    acc_q;
    logic [CW-1:0]         cnt_q;
    logic [2*WIDTH-1:0]    p_q;
    logic                  neg_q;

    logic                  accept;
    logic                  last;
    logic [WIDTH-1:0]      a_mag, b_mag;
    logic                  neg_d;
    logic [WIDTH-1:0]      addend, sum;
    logic                  carry;
    logic [2*WIDTH-1:0]    acc_next;
    logic [2*WIDTH-1:0]    result;

    assign accept = bus.start && (state_q != CALC);
    assign last   = (state_q == CALC) && (cnt_q == CW'(WIDTH - 1));

    always_comb begin
        a_mag = bus.a;
        b_mag = bus.b;
        neg_d = 1'b0;
`ifdef SEQ_MULT_SIGNED_EN
        if (bus.sgn) begin
            if (bus.a[WIDTH-1]) a_mag = ~bus.a + WIDTH'(1);
            if (bus.b[WIDTH-1]) b_mag = ~bus.b + WIDTH'(1);
            neg_d = bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
        end
`endif
    end

    // Low half of the accumulator doubles as the multiplier shift register,
    // so acc_q[0] is always the current multiplier bit.
    assign addend = acc_q[0] ? mcand_q : '0;

    adder_wbit #(.WIDTH(WIDTH)) u_adder (
        .a     (acc_q[2*WIDTH-1:WIDTH]),
        .b     (addend),
        .c_in  (1'b0),
        .s     (sum),
        .c_out (carry)
    );

    assign acc_next = {carry, sum, acc_q[WIDTH-1:1]};
    assign result   = neg_q ? (~acc_next + (2*WIDTH)'(1)) : acc_next;

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = CALC;
            CALC:    if (last)      state_d = FIN;
            FIN:     state_d = bus.start ? CALC : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mcand_q <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            p_q     <= '0;
            neg_q   <= 1'b0;
        end else if (accept) begin
            mcand_q <= a_mag;
            acc_q   <= {{WIDTH{1'b0}}, b_mag};
            cnt_q   <= '0;
            neg_q   <= neg_d;
        end else if (state_q == CALC) begin
            acc_q <= acc_next;
            cnt_q <= cnt_q + CW'(1);
            if (last) p_q <= result;
        end
    end

    assign bus.busy = (state_q == CALC);
    assign bus.done = (state_q == FIN);
    assign bus.p    = p_q;
    assign state    = state_q;
endmodule
